// File: rtl/rx_module.sv
// rx_module: UART receive path (8N1) with an internal receive FIFO.
// The rx pin is brought into the clk domain by a 2-flop synchroniser.
// Each frame is sampled at mid-bit, and good bytes are pushed into a
// circular FIFO that the host drains with rd_req/q.
// Optional build macro RX_PARITY_EN: frames become 8E1 and a parity_err
// pulse output is added. Bytes with bad parity are discarded.
module rx_module #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_req,
    output logic [7:0] q,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
`ifdef RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    // One-hot frame states. ST_PARITY is only entered in the 8E1 build.
    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_START  = 6'b000010,
        ST_DATA   = 6'b000100,
        ST_PARITY = 6'b001000,
        ST_STOP   = 6'b010000,
        ST_BREAK  = 6'b100000
    } state_t;

    logic          rx_meta, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push_req, ferr_n;
`ifdef RX_PARITY_EN
    logic          par, par_n, perr_n;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic          do_push, do_pop, ovr_set;

    // Two-flop synchroniser. It resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM registers: state, bit timer, bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            frame_err <= ferr_n;
`ifdef RX_PARITY_EN
            par        <= par_n;
            parity_err <= perr_n;
`endif
        end
    end

    // Next-state logic. The timer free-runs in each bit state and is
    // cleared whenever a sample is taken.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CW'(1);
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_n   = 1'b0;
`ifdef RX_PARITY_EN
        par_n  = par;
        perr_n = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF) begin
                    cnt_n = '0;
                    idx_n = '0;
                    // A high start-bit sample is a false start (glitch).
                    state_n = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    idx_n          = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    par_n   = rx_s;
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = ST_IDLE;
`ifdef RX_PARITY_EN
                        // Even parity: data plus parity bit must XOR to 0.
                        if (^{shreg, par}) perr_n = 1'b1;
                        else               push_req = 1'b1;
`else
                        push_req = 1'b1;
`endif
                    end else begin
                        // Stop-bit error wins over any parity error.
                        ferr_n  = 1'b1;
                        state_n = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line idles so a held-low line
                // cannot produce a stream of bogus frames.
                cnt_n = '0;
                if (rx_s) state_n = ST_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

    // FIFO control. A pop in the same cycle frees a slot for a push
    // arriving while full, so no overrun is flagged in that case.
    always_comb begin
        do_pop  = rd_req && !fifo_empty;
        do_push = push_req && (!fifo_full || do_pop);
        ovr_set = push_req && fifo_full && !do_pop;
        wr_n    = wr_ptr + PW'(do_push);
        rd_n    = rd_ptr + PW'(do_pop);
    end

    // FIFO storage write port. Entries need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // FIFO pointers, registered full/empty flags, read data and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
            q          <= '0;
            overrun    <= 1'b0;
        end else begin
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            fifo_empty <= (wr_n == rd_n);
            fifo_full  <= (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
            if (do_pop)  q <= mem[rd_ptr[AW-1:0]];
            if (ovr_set) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_module.sv
// Directed testbench for rx_module with CLKS_PER_BIT=8 and FIFO_DEPTH=4.
// Inputs change on the falling edge, and outputs are sampled there too.
module tb_rx_module;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    // Stop-bit sample cycle, counted in falling edges from the start-bit edge.
    localparam int SAMP = CPB * FB - 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_req = 1'b0;
    logic [7:0] q;
    logic       fifo_empty, fifo_full, rx_busy, frame_err, overrun;
`ifdef RX_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int ferr_seen = 0;
    int perr_seen = 0;
    logic [7:0] exp_q[$];

    rx_module #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_req     (rd_req),
        .q          (q),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
`ifdef RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge and tally error pulses.
    task automatic tick();
        @(negedge clk);
        if (frame_err === 1'b1) ferr_seen++;
`ifdef RX_PARITY_EN
        if (parity_err === 1'b1) perr_seen++;
`endif
    endtask

    // Drive one frame. This task captures fifo_empty around the stop sample
    // and can optionally assert rd_req in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par,
                              input logic pop_at_stop, output logic e_before,
                              output logic e_after, output logic [7:0] q_after);
        logic [FB-1:0] bits;
`ifdef RX_PARITY_EN
        bits = {stop_bit, (^d) ^ bad_par, d, 1'b0};
`else
        bits = {stop_bit, d, 1'b0};
        if (bad_par) bits = {stop_bit, d, 1'b0};
`endif
        e_before = 1'bx;
        e_after  = 1'bx;
        q_after  = 8'hxx;
        for (int i = 0; i < CPB * FB; i++) begin
            rx = bits[i / CPB];
            tick();
            if (i + 1 == SAMP) begin
                e_before = fifo_empty;
                if (pop_at_stop) rd_req = 1'b1;
            end
            if (i + 1 == SAMP + 1) begin
                e_after = fifo_empty;
                q_after = q;
                rd_req  = 1'b0;
            end
        end
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        logic eb, ea;
        logic [7:0] qa;
        send_frame(d, 1'b1, 1'b0, 1'b0, eb, ea, qa);
    endtask

    task automatic do_pop(output logic [7:0] v);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        v = q;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h want 00", q); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", fifo_full); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", overrun); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic eb, ea;
        logic [7:0] qa, v;
        send_frame(8'h21, 1'b1, 1'b0, 1'b0, eb, ea, qa);
        n_cmp++; if (eb !== 1'b1) begin n_err++; $display("FAIL single_empty_at_sample: got %b want 1", eb); end
        n_cmp++; if (ea !== 1'b0) begin n_err++; $display("FAIL single_empty_after: got %b want 0", ea); end
        do_pop(v);
        n_cmp++; if (v !== 8'h21) begin n_err++; $display("FAIL single_q: got %h want 21", v); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL single_empty_post_pop: got %b want 1", fifo_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v, e;
        int f0;
        logic [7:0] pat [3];
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'hA5;
        f0 = ferr_seen;
        for (int i = 0; i < 3; i++) begin
            send(pat[i]);
            exp_q.push_back(pat[i]);
        end
        for (int i = 0; i < 3; i++) begin
            do_pop(v);
            e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL b2b_q%0d: got %h want %h", i, v, e); end
        end
        n_cmp++; if (ferr_seen !== f0) begin n_err++; $display("FAIL b2b_ferr: got %0d pulses want 0", ferr_seen - f0); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        tick();
        tick();
        rx = 1'b1;
        tick();
        tick();
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_start: got %b want 1", rx_busy); end
        repeat (6) tick();
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL glitch_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_break();
        logic eb, ea;
        logic [7:0] qa, v;
        int f0;
        f0 = ferr_seen;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, eb, ea, qa);
        rx = 1'b0;
        repeat (30 * CPB) tick();
        n_cmp++; if (ferr_seen !== f0 + 1) begin n_err++; $display("FAIL break_ferr: got %0d pulses want 1", ferr_seen - f0); end
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL break_busy_low: got %b want 1", rx_busy); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL break_no_push: got %b want 1", fifo_empty); end
        rx = 1'b1;
        repeat (4) tick();
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL break_busy_release: got %b want 0", rx_busy); end
        send(8'h3C);
        do_pop(v);
        n_cmp++; if (v !== 8'h3C) begin n_err++; $display("FAIL break_next_q: got %h want 3c", v); end
    endtask

    task automatic test_overrun();
        logic [7:0] v, e;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i * 8'h11));
            exp_q.push_back(8'(i * 8'h11));
        end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL ovr_full: got %b want 1", fifo_full); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %b want 0", overrun); end
        send(8'h55);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v);
            e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL ovr_q%0d: got %h want %h", i, v, e); end
        end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL ovr_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        logic [7:0] v;
        send(8'h99);
        bits = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 30; i++) begin
            rx = bits[i / CPB];
            tick();
        end
        rst = 1'b1;
        rx  = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_mid_q: got %h want 00", q); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL rst_mid_empty: got %b want 1", fifo_empty); end
        n_cmp++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL rst_mid_full: got %b want 0", fifo_full); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", rx_busy); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovr: got %b want 0", overrun); end
        repeat (4) tick();
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: got %b want 0", rx_busy); end
        send(8'h42);
        do_pop(v);
        n_cmp++; if (v !== 8'h42) begin n_err++; $display("FAIL rst_mid_next_q: got %h want 42", v); end
`ifdef RX_PARITY_EN
        begin
            logic eb, ea;
            logic [7:0] qa;
            int p0;
            p0 = perr_seen;
            send_frame(8'h42, 1'b1, 1'b1, 1'b0, eb, ea, qa);
            tick();
            n_cmp++; if (perr_seen !== p0 + 1) begin n_err++; $display("FAIL parity_err_pulse: got %0d want 1", perr_seen - p0); end
            n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL parity_no_push: got %b want 1", fifo_empty); end
        end
`endif
    endtask

    task automatic test_pop_at_full();
        logic eb, ea;
        logic [7:0] qa, v, e;
        for (int i = 1; i <= 4; i++) begin
            send(8'hA0 + 8'(i));
            exp_q.push_back(8'hA0 + 8'(i));
        end
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, eb, ea, qa);
        e = exp_q.pop_front();
        n_cmp++; if (qa !== e) begin n_err++; $display("FAIL popfull_q: got %h want %h", qa, e); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL popfull_ovr: got %b want 0", overrun); end
        n_cmp++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL popfull_full: got %b want 1", fifo_full); end
        for (int i = 0; i < 4; i++) begin
            do_pop(v);
            e = exp_q.pop_front();
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL popfull_drain%0d: got %h want %h", i, v, e); end
        end
        // A pop request while empty must leave q untouched.
        do_pop(v);
        n_cmp++; if (v !== 8'hA5) begin n_err++; $display("FAIL empty_pop_hold: got %h want a5", v); end
        n_cmp++; if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL empty_pop_empty: got %b want 1", fifo_empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        test_pop_at_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
